vga_regbank_arbiter: RTL and testbench

- Owns the shared 16x8 display register bank (time/date digits, cursor, format bytes) that the VGA controller reads through its 4-bit address / 8-bit data port.
- Arbitrates single-port access between two requesters: port A is the VGA controller (read-only, latency critical); port B is the RTC/keyboard update side (read/write).
- A is favoured; B is guaranteed a slot after a bounded wait.
- Sits between ControlVGA, the RTC interface and the storage, replacing the free-running memory the VGA side reads today.

---
 rtl/vga_regbank_pkg.sv | 29 ++
 rtl/regbank_16x8.sv | 39 +++
 rtl/vga_regbank_arbiter.sv | 114 +++++++++++
 tb/tb_vga_regbank_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_regbank_pkg.sv
// Shared definitions for the VGA display register bank and its arbiter:
// FSM state encoding, default widths and the named byte addresses that the
// VGA controller and the RTC/keyboard side agree on.
package vga_regbank_pkg;

    localparam int unsigned ADDR_W_DEF     = 4;
    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // Last-winner register: decides which grant is high this cycle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_A    = 2'd1,
        ST_B    = 2'd2
    } state_t;

    // Display byte map shared by ControlVGA and the RTC interface.
    localparam logic [3:0] ADDR_CURSOR  = 4'd0;
    localparam logic [3:0] ADDR_HOUR    = 4'd1;
    localparam logic [3:0] ADDR_MIN     = 4'd2;
    localparam logic [3:0] ADDR_SEC     = 4'd3;
    localparam logic [3:0] ADDR_DAY     = 4'd4;
    localparam logic [3:0] ADDR_MONTH   = 4'd5;
    localparam logic [3:0] ADDR_YEAR    = 4'd6;
    localparam logic [3:0] ADDR_WEEKDAY = 4'd7;
    localparam logic [3:0] ADDR_ALARM   = 4'd8;
    localparam logic [3:0] ADDR_FORMAT  = 4'd9;

endpackage

// File: rtl/regbank_16x8.sv
// Single-port display register file with asynchronous active-low clear.
// The read port is a plain mux of the addressed entry; the arbiter captures
// it into its read-data registers on the same edge the access is granted.
// Ports:
//   clk, rst_n : clock, async active-low clear of every entry
//   we         : write strobe for the addressed entry
//   addr       : entry address
//   wdata      : write data
//   rdata_c    : contents of the addressed entry (combinational)
module regbank_16x8 #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage: whole bank zeroed on reset, one write per edge otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/vga_regbank_arbiter.sv
// Display register bank with a two-requester single-port arbiter.
// Port A (VGA controller, read-only) is favoured; port B (RTC/keyboard,
// read/write) wins after losing STARVE_MAX consecutive edges to A.
// Ports:
//   CLK, RESET           : clock, async active-low reset
//   req_a, addr_a        : VGA read request and address
//   gnt_a, rdata_a       : grant pulse and held read data for A
//   req_b, we_b, addr_b,
//   wdata_b              : RTC/keyboard request, write enable, address, data
//   gnt_b, rdata_b       : grant pulse and held read data for B
//   busy                 : B is pending and has lost at least one edge to A
module vga_regbank_arbiter
    import vga_regbank_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic              gnt_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy
);

    // STARVE_MAX is at most 15, so a 4-bit counter never needs to wrap.
    localparam int unsigned   CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  next_cnt;
    logic              win_a;
    logic              win_b;
    logic              bank_we;
    logic [ADDR_W-1:0] bank_addr;
    logic [DATA_W-1:0] bank_rdata;

    // Winner selection and starvation counter update.
    always_comb begin
        next_state = ST_IDLE;
        next_cnt   = '0;
        win_a      = 1'b0;
        win_b      = 1'b0;
        if (req_a && req_b) begin
            if (wait_cnt < CNT_MAX) begin
                win_a    = 1'b1;
                next_cnt = wait_cnt + CNT_W'(1);
            end else begin
                win_b    = 1'b1;
            end
        end else if (req_a) begin
            win_a = 1'b1;
        end else if (req_b) begin
            win_b = 1'b1;
        end
        if (win_a) begin
            next_state = ST_A;
        end else if (win_b) begin
            next_state = ST_B;
        end
    end

    // Single bank port follows whoever wins this edge.
    assign bank_we   = win_b & we_b;
    assign bank_addr = win_b ? addr_b : addr_a;

    regbank_16x8 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bank (
        .clk     (CLK),
        .rst_n   (RESET),
        .we      (bank_we),
        .addr    (bank_addr),
        .wdata   (wdata_b),
        .rdata_c (bank_rdata)
    );

    // State, counter and read-data registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            busy     <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
            busy     <= (next_cnt != '0);
            if (win_a) begin
                rdata_a <= bank_rdata;
            end
            if (win_b && !we_b) begin
                rdata_b <= bank_rdata;
            end
        end
    end

    // Grants are a direct decode of the last-winner register.
    assign gnt_a = (state == ST_A);
    assign gnt_b = (state == ST_B);

endmodule

// File: tb/tb_vga_regbank_arbiter.sv
// Bench for vga_regbank_arbiter: a behavioural bank/arbiter model checked
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_vga_regbank_arbiter;
    import vga_regbank_pkg::*;

    localparam int SM = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       req_a = 1'b0;
    logic [3:0] addr_a = 4'd0;
    logic       gnt_a;
    logic [7:0] rdata_a;
    logic       req_b = 1'b0;
    logic       we_b = 1'b0;
    logic [3:0] addr_b = 4'd0;
    logic [7:0] wdata_b = 8'd0;
    logic       gnt_b;
    logic [7:0] rdata_b;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    vga_regbank_arbiter #(
        .ADDR_W     (4),
        .DATA_W     (8),
        .STARVE_MAX (SM)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .req_a   (req_a),
        .addr_a  (addr_a),
        .gnt_a   (gnt_a),
        .rdata_a (rdata_a),
        .req_b   (req_b),
        .we_b    (we_b),
        .addr_b  (addr_b),
        .wdata_b (wdata_b),
        .gnt_b   (gnt_b),
        .rdata_b (rdata_b),
        .busy    (busy)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: B is served when A is absent or B has already
    // lost SM edges in a row; otherwise A is served.
    logic [7:0] m_bank [16];
    logic       m_gnt_a = 1'b0;
    logic       m_gnt_b = 1'b0;
    logic       m_busy = 1'b0;
    logic [7:0] m_rd_a = 8'd0;
    logic [7:0] m_rd_b = 8'd0;
    int         m_losses = 0;
    logic       b_turn;
    logic       a_turn;

    initial begin
        foreach (m_bank[i]) m_bank[i] = 8'd0;
    end

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            foreach (m_bank[i]) m_bank[i] = 8'd0;
            m_gnt_a  = 1'b0;
            m_gnt_b  = 1'b0;
            m_busy   = 1'b0;
            m_rd_a   = 8'd0;
            m_rd_b   = 8'd0;
            m_losses = 0;
        end else begin
            b_turn = req_b && (!req_a || m_losses >= SM);
            a_turn = req_a && !b_turn;
            if (a_turn) m_rd_a = m_bank[addr_a];
            if (b_turn) begin
                if (we_b) m_bank[addr_b] = wdata_b;
                else      m_rd_b = m_bank[addr_b];
            end
            if (!req_b || b_turn) m_losses = 0;
            else                  m_losses = m_losses + 1;
            m_gnt_a = a_turn;
            m_gnt_b = b_turn;
            m_busy  = (m_losses != 0);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        cmp("cyc_gnt_a",   32'(gnt_a),   32'(m_gnt_a));
        cmp("cyc_gnt_b",   32'(gnt_b),   32'(m_gnt_b));
        cmp("cyc_rdata_a", 32'(rdata_a), 32'(m_rd_a));
        cmp("cyc_rdata_b", 32'(rdata_b), 32'(m_rd_b));
        cmp("cyc_busy",    32'(busy),    32'(m_busy));
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    int n_a;

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(posedge CLK);
        #1;
        cmp("rst_gnt_a",   32'(gnt_a),   32'h0);
        cmp("rst_gnt_b",   32'(gnt_b),   32'h0);
        cmp("rst_rdata_a", 32'(rdata_a), 32'h0);
        cmp("rst_rdata_b", 32'(rdata_b), 32'h0);
        cmp("rst_busy",    32'(busy),    32'h0);
        RESET = 1'b1;

        // A sweeps the whole bank after reset
        for (int i = 0; i < 16; i++) begin
            req_a  = 1'b1;
            addr_a = 4'(i);
            step();
            cmp("sweep_gnt_a",   32'(gnt_a),   32'h1);
            cmp("sweep_rdata_a", 32'(rdata_a), 32'h0);
        end
        req_a = 1'b0;

        // B write, B read back, A read back
        req_b = 1'b1; we_b = 1'b1; addr_b = ADDR_HOUR; wdata_b = 8'h1E;
        step();
        cmp("bwr_gnt_b", 32'(gnt_b), 32'h1);
        cmp("bwr_gnt_a", 32'(gnt_a), 32'h0);
        we_b = 1'b0;
        step();
        cmp("brd_gnt_b",   32'(gnt_b),   32'h1);
        cmp("brd_rdata_b", 32'(rdata_b), 32'h1E);
        req_b = 1'b0;
        req_a = 1'b1; addr_a = ADDR_HOUR;
        step();
        cmp("ard_rdata_a", 32'(rdata_a), 32'h1E);
        req_a = 1'b0;

        // Simultaneous request: A first, B's write lands only when granted
        req_a = 1'b1; addr_a = ADDR_ALARM;
        req_b = 1'b1; we_b = 1'b1; addr_b = ADDR_ALARM; wdata_b = 8'h32;
        step();
        cmp("pri_gnt_a",   32'(gnt_a),   32'h1);
        cmp("pri_gnt_b",   32'(gnt_b),   32'h0);
        cmp("pri_rdata_a", 32'(rdata_a), 32'h0);
        cmp("pri_busy",    32'(busy),    32'h1);
        req_a = 1'b0;
        step();
        cmp("pri_late_gnt_b", 32'(gnt_b), 32'h1);
        cmp("pri_late_busy",  32'(busy),  32'h0);
        req_b = 1'b0;
        req_a = 1'b1;
        step();
        cmp("pri_after_rdata_a", 32'(rdata_a), 32'h32);
        req_a = 1'b0;
        step();
        cmp("idle_gnt_a",   32'(gnt_a),   32'h0);
        cmp("idle_rdata_a", 32'(rdata_a), 32'h32);

        // Starvation bound: 4 A grants, then B, then A again
        req_a = 1'b1; addr_a = ADDR_CURSOR;
        req_b = 1'b1; we_b = 1'b0; addr_b = ADDR_HOUR;
        n_a = 0;
        for (int k = 0; k < SM; k++) begin
            step();
            if (gnt_a) n_a++;
            cmp("starve_busy", 32'(busy), 32'h1);
        end
        cmp("starve_a_count", 32'(n_a), 32'd4);
        step();
        cmp("starve_gnt_b",   32'(gnt_b),   32'h1);
        cmp("starve_rdata_b", 32'(rdata_b), 32'h1E);
        cmp("starve_busy_clr", 32'(busy),   32'h0);
        req_b = 1'b0;
        step();
        cmp("starve_resume_a", 32'(gnt_a), 32'h1);
        req_a = 1'b0;

        // Preload minute byte, then back-to-back A reads of 0,1,2
        req_b = 1'b1; we_b = 1'b1; addr_b = ADDR_MIN; wdata_b = 8'h5A;
        step();
        req_b = 1'b0;
        req_a = 1'b1; addr_a = 4'd0;
        step();
        cmp("b2b_rd0", 32'(rdata_a), 32'h00);
        addr_a = 4'd1;
        step();
        cmp("b2b_rd1", 32'(rdata_a), 32'h1E);
        cmp("b2b_gnt", 32'(gnt_a),   32'h1);
        addr_a = 4'd2;
        step();
        cmp("b2b_rd2", 32'(rdata_a), 32'h5A);
        req_a = 1'b0;

        // Reset in the middle of a pending B write
        req_b = 1'b1; we_b = 1'b1; addr_b = ADDR_MIN; wdata_b = 8'h0F;
        #3;
        RESET = 1'b0;
        #1;
        cmp("mid_rst_gnt_a",   32'(gnt_a),   32'h0);
        cmp("mid_rst_rdata_a", 32'(rdata_a), 32'h0);
        cmp("mid_rst_rdata_b", 32'(rdata_b), 32'h0);
        cmp("mid_rst_busy",    32'(busy),    32'h0);
        req_b = 1'b0;
        step();
        step();
        #2;
        RESET = 1'b1;
        step();
        cmp("post_rst_no_gnt_b", 32'(gnt_b), 32'h0);
        req_a = 1'b1; addr_a = ADDR_MIN;
        step();
        cmp("post_rst_bank2", 32'(rdata_a), 32'h0);
        req_a = 1'b0;
        req_b = 1'b1; we_b = 1'b0; addr_b = ADDR_ALARM;
        step();
        cmp("rereq_gnt_b",   32'(gnt_b),   32'h1);
        cmp("rereq_rdata_b", 32'(rdata_b), 32'h0);
        req_b = 1'b0;

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
